// File: rtl/wrr_grant_if.sv
// Handshake bundle between the requester front-ends (master) and the
// weighted round-robin grant scheduler (slave).
interface wrr_grant_if #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int IW = 2
) ();
  logic [N-1:0]    req;
  logic [N*CW-1:0] weight;
  logic            done;
  logic [N-1:0]    grant;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_id;
  logic [CW-1:0]   credit;

  modport master (
    output req,
    output weight,
    output done,
    input  grant,
    input  gnt_vld,
    input  gnt_id,
    input  credit
  );

  modport slave (
    input  req,
    input  weight,
    input  done,
    output grant,
    output gnt_vld,
    output gnt_id,
    output credit
  );
endinterface

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin scheduler: each grantee keeps the shared resource for up to
// weight[i] completed transfers, then the grant rotates with no idle bubble.
module wrr_grant_scheduler #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int IW = 2
) (
  input  logic           clk,
  input  logic           rst,
  wrr_grant_if.slave     bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [CW-1:0] credit_q, credit_d;

  // Rotating search starting at p; returns {found, index}.
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic          found;
    logic [IW-1:0] idx;
    int            cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(p) + k) % N;
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
    return {found, idx};
  endfunction

  // A zero weight still grants one transfer so a requester can never be starved.
  function automatic logic [CW-1:0] sat_weight(input logic [CW-1:0] w);
    return (w == '0) ? CW'(1) : w;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [IW:0]   pick_idle;
  logic [IW:0]   pick_rel;
  logic [IW-1:0] rel_ptr;
  logic          grantee_req;
  logic          rel_now;

  always_comb begin
    rel_ptr     = IW'((int'(gnt_id_q) + 1) % N);
    pick_idle   = pick(bus.req, ptr_q);
    // Searching from the slot after the grantee places the grantee last, so it
    // is re-picked only when nobody else is waiting.
    pick_rel    = pick(bus.req, rel_ptr);
    grantee_req = bus.req[gnt_id_q];
    rel_now     = (state_q == BUSY) &&
                  (!grantee_req || (bus.done && (credit_q == CW'(1))));
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    gnt_id_d = gnt_id_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE: begin
        if (pick_idle[IW]) begin
          state_d  = BUSY;
          gnt_id_d = pick_idle[IW-1:0];
          grant_d  = onehot(pick_idle[IW-1:0]);
          credit_d = sat_weight(bus.weight[pick_idle[IW-1:0]*CW +: CW]);
        end
      end
      BUSY: begin
        if (rel_now) begin
          ptr_d = rel_ptr;
          if (pick_rel[IW]) begin
            gnt_id_d = pick_rel[IW-1:0];
            grant_d  = onehot(pick_rel[IW-1:0]);
            credit_d = sat_weight(bus.weight[pick_rel[IW-1:0]*CW +: CW]);
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            credit_d = '0;
          end
        end else if (bus.done) begin
          credit_d = credit_q - CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      gnt_id_q <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      gnt_id_q <= gnt_id_d;
      credit_q <= credit_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.gnt_vld = |grant_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.credit  = credit_q;

endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// Directed bench for wrr_grant_scheduler: reset, single requester, rotation,
// weighted durations, abandon/zero weight and hold scenarios.
module tb_wrr_grant_scheduler;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  wrr_grant_if #(.N(N), .CW(CW), .IW(IW)) bus ();

  wrr_grant_scheduler #(.N(N), .CW(CW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input logic [CW-1:0] w3, input logic [CW-1:0] w2,
                             input logic [CW-1:0] w1, input logic [CW-1:0] w0);
    bus.weight = {w3, w2, w1, w0};
  endtask

  task automatic do_reset();
    bus.req  = '0;
    bus.done = 1'b0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.grant !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.gnt_id !== 2'd0 || bus.credit !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_idle: grant=%b vld=%b id=%0d credit=%0d, want 0000/0/0/0",
               bus.grant, bus.gnt_vld, bus.gnt_id, bus.credit);
    end
    // Put the scheduler in BUSY, then reset mid-cycle.
    set_weights(4'd1, 4'd1, 4'd1, 4'd3);
    bus.req = 4'b0001;
    tick();
    vectors++;
    if (bus.grant !== 4'b0001 || bus.credit !== 4'd3) begin
      miscompares++;
      $display("FAIL reset_pre_busy: grant=%b credit=%0d, want 0001/3", bus.grant, bus.credit);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.grant !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.credit !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_async: grant=%b vld=%b credit=%0d, want 0000/0/0",
               bus.grant, bus.gnt_vld, bus.credit);
    end
    #1;
    rst = 1'b0;
    bus.req = 4'b1010;
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd1 || bus.grant !== 4'b0010 || bus.gnt_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ptr0: id=%0d grant=%b vld=%b, want 1/0010/1",
               bus.gnt_id, bus.grant, bus.gnt_vld);
    end
  endtask

  task automatic test_single();
    logic [CW-1:0] exp_cr [4] = '{4'd3, 4'd2, 4'd1, 4'd3};
    do_reset();
    set_weights(4'd1, 4'd1, 4'd1, 4'd3);
    bus.req  = 4'b0001;
    bus.done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (bus.grant !== 4'b0001 || bus.credit !== exp_cr[c]) begin
        miscompares++;
        $display("FAIL single_c%0d: grant=%b credit=%0d, want 0001/%0d",
                 c, bus.grant, bus.credit, exp_cr[c]);
      end
    end
    // Dropping the request releases the grant and with nobody waiting goes idle.
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    tick();
    vectors++;
    if (bus.grant !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.credit !== 4'd0) begin
      miscompares++;
      $display("FAIL single_idle: grant=%b vld=%b credit=%0d, want 0000/0/0",
               bus.grant, bus.gnt_vld, bus.credit);
    end
  endtask

  task automatic test_rotation();
    logic [IW-1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    set_weights(4'd1, 4'd1, 4'd1, 4'd1);
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (bus.gnt_id !== exp_id[c] || bus.grant !== (4'b0001 << exp_id[c]) || bus.credit !== 4'd1) begin
        miscompares++;
        $display("FAIL rotation_c%0d: id=%0d grant=%b credit=%0d, want id %0d credit 1",
                 c, bus.gnt_id, bus.grant, bus.credit, exp_id[c]);
      end
    end
  endtask

  task automatic test_weighted();
    logic [IW-1:0] exp_id [12] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3,
                                   2'd3, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [CW-1:0] exp_cr [12] = '{4'd1, 4'd2, 4'd1, 4'd1, 4'd4, 4'd3,
                                   4'd2, 4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
    do_reset();
    set_weights(4'd4, 4'd1, 4'd2, 4'd1);
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      vectors++;
      if (bus.gnt_id !== exp_id[c] || bus.credit !== exp_cr[c] || bus.gnt_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL weighted_c%0d: id=%0d credit=%0d vld=%b, want id %0d credit %0d vld 1",
                 c, bus.gnt_id, bus.credit, bus.gnt_vld, exp_id[c], exp_cr[c]);
      end
    end
  endtask

  task automatic test_abandon();
    do_reset();
    set_weights(4'd1, 4'd5, 4'd1, 4'd1);
    bus.req  = 4'b0100;
    bus.done = 1'b0;
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd2 || bus.credit !== 4'd5) begin
      miscompares++;
      $display("FAIL abandon_setup: id=%0d credit=%0d, want 2/5", bus.gnt_id, bus.credit);
    end
    // Grantee 2 walks away without a done; weight 0 on requester 3 means one transfer.
    set_weights(4'd0, 4'd5, 4'd1, 4'd1);
    bus.req = 4'b1001;
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd3 || bus.grant !== 4'b1000 || bus.credit !== 4'd1) begin
      miscompares++;
      $display("FAIL abandon_handover: id=%0d grant=%b credit=%0d, want 3/1000/1",
               bus.gnt_id, bus.grant, bus.credit);
    end
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd3 || bus.credit !== 4'd1) begin
      miscompares++;
      $display("FAIL zero_weight_hold: id=%0d credit=%0d, want 3/1", bus.gnt_id, bus.credit);
    end
    bus.done = 1'b1;
    tick();
    vectors++;
    if (bus.gnt_id !== 2'd0 || bus.grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL zero_weight_one_done: id=%0d grant=%b, want 0/0001", bus.gnt_id, bus.grant);
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_weights(4'd1, 4'd1, 4'd5, 4'd1);
    bus.req  = 4'b0010;
    bus.done = 1'b0;
    tick();
    bus.req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (bus.grant !== 4'b0010 || bus.credit !== 4'd5) begin
        miscompares++;
        $display("FAIL hold_c%0d: grant=%b credit=%0d, want 0010/5", c, bus.grant, bus.credit);
      end
    end
    bus.done = 1'b1;
    tick();
    vectors++;
    if (bus.grant !== 4'b0010 || bus.credit !== 4'd4) begin
      miscompares++;
      $display("FAIL hold_resume: grant=%b credit=%0d, want 0010/4", bus.grant, bus.credit);
    end
  endtask

  initial begin
    bus.req    = '0;
    bus.weight = '0;
    bus.done   = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_weighted();
    test_abandon();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
